register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the address width; register count is 2**ADDR_WIDTH (32).
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 regwrite  input  1  SHALL be the write enable, sampled on rising clk.
REQ-006 read_reg_1  input  ADDR_WIDTH  SHALL be the read port 1 address.
REQ-007 read_reg_2  input  ADDR_WIDTH  SHALL be the read port 2 address.
REQ-008 write_reg  input  ADDR_WIDTH  SHALL be the write port address.
REQ-009 write_data  input  DATA_WIDTH  SHALL be the write port data.
REQ-010 read_data_1  output  DATA_WIDTH  SHALL be the contents of register read_reg_1.
REQ-011 read_data_2  output  DATA_WIDTH  SHALL be the contents of register read_reg_2.

Function
REQ-012 Storage SHALL be 32 registers of DATA_WIDTH bits, indices 0..31.
REQ-013 Reads SHALL be combinational: each read_data_N follows its address and stored contents with zero clock latency.
REQ-014 The two read ports SHALL be independent; the same address on both ports SHALL return identical data.
REQ-015 On a rising clk with regwrite=1 and write_reg!=0, write_data SHALL be stored in register write_reg.
REQ-016 With regwrite=0, no register SHALL change.
REQ-017 Register 0 SHALL always read 0; writes to address 0 SHALL be ignored regardless of regwrite.
REQ-018 No write-through bypass: a read of write_reg in the cycle of its write SHALL return the old value until the rising edge, and the new value thereafter.
REQ-019 Repeated writes of the same value to the same register SHALL leave it unchanged and SHALL have no side effects on other registers.
REQ-020 Only the addressed register SHALL be updated on a write; all others SHALL hold.
REQ-021 Read outputs SHALL never be X/Z once reset has been applied.

Reset
REQ-022 While reset=1, all 32 registers SHALL be cleared to 0 immediately, independent of clk.
REQ-023 reset SHALL take priority over a simultaneous write; a write with reset asserted SHALL be discarded.
REQ-024 Reset asserted mid-operation SHALL clear all registers asynchronously; read outputs SHALL show 0 combinationally.
REQ-025 After reset deasserts, the first write SHALL occur on the next rising clk with regwrite=1.

Structure
REQ-026 DATA_WIDTH, ADDR_WIDTH, and register-count defaults SHALL be defined in the shared MIPS processor package.
REQ-027 The block SHALL be a single module with no sub-modules; storage is a register array with one always block for reset/write and continuous assignments for reads.

Verification
REQ-028 Assert reset, release; read_reg_1=0, read_reg_2=1 -> read_data_1=0, read_data_2=0.
REQ-029 regwrite=1, write_reg=2, write_data=1, one rising clk; read_reg_1=2, read_reg_2=1 -> read_data_1=1, read_data_2=0.
REQ-030 regwrite=0, write_reg=3, write_data=32'hDEADBEEF, one clk; read_reg_1=3 -> 0.
REQ-031 regwrite=1, write_reg=0, write_data=32'hFFFFFFFF, one clk; read_reg_1=0 -> 0.
REQ-032 Write 32'h12345678 to register 31, then read_reg_1=31, read_reg_2=31 -> both outputs 32'h12345678; assert reset between clk edges -> both 0 immediately.
REQ-033 Same-cycle check: write_reg=5, write_data=7, read_reg_1=5 -> read_data_1=0 before the edge, 7 after.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared MIPS processor package: default widths and register count used by the register file.
package register_file_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_REGS_DEF   = 1 << ADDR_WIDTH_DEF;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Two-read, one-write MIPS register file with a hardwired-zero register 0.
// Reads are combinational with no write-through bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  write_en;

    // Address 0 is never written, so register 0 stays at its reset value of zero.
    assign write_en = regwrite && (write_reg != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[write_reg] = write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign read_data_1 = (read_reg_1 == '0) ? '0 : regs_q[read_reg_1];
    assign read_data_2 = (read_reg_2 == '0) ? '0 : regs_q[read_reg_2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, writes, zero register,
// same-cycle read, full-array pattern and asynchronous reset mid-operation.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic        regwrite;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int tests;
    int fails;

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .regwrite   (regwrite),
        .read_reg_1 (read_reg_1),
        .read_reg_2 (read_reg_2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a write between edges, commit it on the next rising edge, then drop regwrite.
    task automatic do_write(input logic en, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        regwrite   = en;
        write_reg  = addr;
        write_data = data;
        @(posedge clk);
        #1;
        regwrite = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int unsigned i);
        logic [31:0] v;
        v = (i * 32'h0101_0101) ^ 32'hA5C3_0F00;
        return (i == 0) ? 32'h0 : v;
    endfunction

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        regwrite   = 1'b0;
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd1;
        write_reg  = 5'd0;
        write_data = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd1", read_data_1, 32'h0);
        check("reset_rd2", read_data_2, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_r0", read_data_1, 32'h0);
        check("post_reset_r1", read_data_2, 32'h0);

        // Basic write to register 2
        do_write(1'b1, 5'd2, 32'h1);
        read_reg_1 = 5'd2;
        read_reg_2 = 5'd1;
        #1;
        check("wr2_rd1", read_data_1, 32'h1);
        check("wr2_rd2_r1", read_data_2, 32'h0);

        // Disabled write leaves register 3 at zero
        do_write(1'b0, 5'd3, 32'hDEAD_BEEF);
        read_reg_1 = 5'd3;
        #1;
        check("nowrite_r3", read_data_1, 32'h0);

        // Write to register 0 is ignored
        do_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        read_reg_1 = 5'd0;
        #1;
        check("wr0_ignored", read_data_1, 32'h0);

        // Same-cycle write: old value before the edge, new value after
        @(negedge clk);
        regwrite   = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'd7;
        read_reg_1 = 5'd5;
        #1;
        check("same_cycle_before", read_data_1, 32'h0);
        @(posedge clk);
        #1;
        check("same_cycle_after", read_data_1, 32'd7);
        regwrite = 1'b0;

        // Register 31 on both ports, others hold
        do_write(1'b1, 5'd31, 32'h1234_5678);
        read_reg_1 = 5'd31;
        read_reg_2 = 5'd31;
        #1;
        check("r31_port1", read_data_1, 32'h1234_5678);
        check("r31_port2", read_data_2, 32'h1234_5678);
        read_reg_1 = 5'd2;
        read_reg_2 = 5'd5;
        #1;
        check("hold_r2", read_data_1, 32'h1);
        check("hold_r5", read_data_2, 32'd7);

        // Repeated identical write has no side effects
        do_write(1'b1, 5'd31, 32'h1234_5678);
        do_write(1'b1, 5'd31, 32'h1234_5678);
        read_reg_1 = 5'd31;
        read_reg_2 = 5'd2;
        #1;
        check("rewrite_r31", read_data_1, 32'h1234_5678);
        check("rewrite_hold_r2", read_data_2, 32'h1);

        // Fill every register with a distinct pattern, then read back on both ports
        for (int unsigned i = 0; i < 32; i++) begin
            do_write(1'b1, 5'(i), pat(i));
        end
        for (int unsigned i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            check($sformatf("fill_p1_r%0d", i), read_data_1, pat(i));
            check($sformatf("fill_p2_r%0d", 31 - i), read_data_2, pat(31 - i));
        end

        // Asynchronous reset between edges clears outputs immediately
        read_reg_1 = 5'd31;
        read_reg_2 = 5'd7;
        @(posedge clk);
        #2;
        check("pre_async_r31", read_data_1, pat(31));
        reset = 1'b1;
        #1;
        check("async_rst_rd1", read_data_1, 32'h0);
        check("async_rst_rd2", read_data_2, 32'h0);

        // Reset wins over a simultaneous write
        @(negedge clk);
        regwrite   = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("rst_priority_r7", read_data_2, 32'h0);

        // First write after reset release lands on the next edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("released_r7", read_data_2, 32'h0);
        @(posedge clk);
        #1;
        regwrite = 1'b0;
        check("first_write_r7", read_data_2, 32'hCAFE_F00D);
        check("other_still_zero_r31", read_data_1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_register_file
